// File: rtl/coax_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : coax_pkg                                               |
// | Description : Shared frame-status codes, controller state encoding   |
// |               and receiver error codes for the coax receive path.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package coax_pkg;

    localparam logic [1:0] c_status_ok        = 2'b00;
    localparam logic [1:0] c_status_truncated = 2'b01;
    localparam logic [1:0] c_status_error     = 2'b10;
    localparam logic [1:0] c_status_aborted   = 2'b11;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_receive = 3'd1;
    localparam logic [2:0] c_st_error   = 3'd2;
    localparam logic [2:0] c_st_recover = 3'd3;
    localparam logic [2:0] c_st_quiet   = 3'd4;

    // Code presented on rx_data by coax_buffered_rx when its FIFO overflows.
    localparam logic [9:0] c_err_overflow = 10'b0000001000;

endpackage : coax_pkg
`default_nettype wire

// File: rtl/coax_rx_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : coax_rx_frame_ctrl                                     |
// | Description : Frame sequencer between coax_buffered_rx and the host: |
// |               streams FIFO words, counts/limits frames, recovers.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module coax_rx_frame_ctrl
    import coax_pkg::*;
#(
    parameter int MAX_WORDS    = 1024,
    parameter int QUIET_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        abort,
    input  logic        rx_active,
    input  logic        rx_error,
    input  logic [9:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_read_strobe,
    output logic        rx_reset,
    output logic [9:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done,
    output logic [10:0] frame_words,
    output logic [1:0]  frame_status,
    output logic [9:0]  error_code,
    output logic        busy
);

    localparam int          c_qw          = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [c_qw-1:0] c_quiet_last = c_qw'(QUIET_CYCLES - 1);
    localparam logic [10:0] c_max_words   = 11'(MAX_WORDS);

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [10:0]     r_count;
    logic            r_trunc;
    logic [c_qw-1:0] r_quiet;
    logic [9:0]      r_out_data;
    logic            r_out_valid;
    logic            r_frame_done;
    logic [10:0]     r_frame_words;
    logic [1:0]      r_frame_status;
    logic [9:0]      r_error_code;
    logic            r_rx_reset;
    logic            r_busy;

    logic            w_strobe;
    logic            w_start;
    logic            w_load;
    logic            w_discard;
    logic            w_flush;
    logic            w_done;
    logic [1:0]      w_done_status;
    logic            w_capture_err;
    logic            w_rx_reset;
    logic            w_quiet_clr;
    logic            w_quiet_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_strobe      = 1'b0;
        w_start       = 1'b0;
        w_load        = 1'b0;
        w_discard     = 1'b0;
        w_flush       = 1'b0;
        w_done        = 1'b0;
        w_done_status = c_status_ok;
        w_capture_err = 1'b0;
        w_rx_reset    = 1'b0;
        w_quiet_clr   = 1'b0;
        w_quiet_inc   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (rx_error) begin
                    w_start      = 1'b1;
                    w_state_next = c_st_error;
                end else if (enable && (rx_active || !rx_empty)) begin
                    w_start      = 1'b1;
                    w_state_next = c_st_receive;
                end
            end
            c_st_receive: begin
                if (rx_error) begin
                    w_state_next = c_st_error;
                end else begin
                    w_strobe = !rx_empty && (!r_out_valid || out_ready);
                    if (!rx_active && rx_empty && !r_out_valid) begin
                        w_done        = 1'b1;
                        w_done_status = r_trunc ? c_status_truncated : c_status_ok;
                        w_state_next  = c_st_idle;
                    end else if (abort) begin
                        // A word popped in this cycle is lost; rx_reset flushes the rest.
                        w_done        = 1'b1;
                        w_done_status = c_status_aborted;
                        w_flush       = 1'b1;
                        w_state_next  = c_st_recover;
                    end else if (w_strobe) begin
                        if (r_count < c_max_words) begin
                            w_load = 1'b1;
                        end else begin
                            w_discard = 1'b1;
                        end
                    end
                end
            end
            c_st_error: begin
                w_capture_err = 1'b1;
                w_flush       = 1'b1;
                w_done        = 1'b1;
                w_done_status = c_status_error;
                w_state_next  = c_st_recover;
            end
            c_st_recover: begin
                w_rx_reset   = 1'b1;
                w_quiet_clr  = 1'b1;
                w_state_next = c_st_quiet;
            end
            c_st_quiet: begin
                if (rx_active) begin
                    w_quiet_clr = 1'b1;
                end else if (r_quiet == c_quiet_last) begin
                    w_state_next = c_st_idle;
                end else begin
                    w_quiet_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= 11'd0;
            r_trunc        <= 1'b0;
            r_quiet        <= '0;
            r_out_data     <= 10'd0;
            r_out_valid    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_words  <= 11'd0;
            r_frame_status <= c_status_ok;
            r_error_code   <= 10'd0;
            r_rx_reset     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_frame_done <= w_done;
            r_rx_reset   <= w_rx_reset;
            r_busy       <= (w_state_next != c_st_idle);

            // Loads stop at c_max_words, so the counter saturates without a wrap check.
            if (w_start) begin
                r_count <= 11'd0;
                r_trunc <= 1'b0;
            end else begin
                if (w_load) begin
                    r_count <= r_count + 11'd1;
                end
                if (w_discard) begin
                    r_trunc <= 1'b1;
                end
            end

            // A load only happens when the register is empty or being drained.
            if (w_flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= rx_data;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_done) begin
                r_frame_words  <= r_count;
                r_frame_status <= w_done_status;
            end

            if (w_capture_err) begin
                r_error_code <= rx_data;
            end

            if (w_quiet_clr) begin
                r_quiet <= '0;
            end else if (w_quiet_inc) begin
                r_quiet <= r_quiet + 1'b1;
            end
        end
    end

    assign rx_read_strobe = w_strobe;
    assign rx_reset       = r_rx_reset;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign frame_done     = r_frame_done;
    assign frame_words    = r_frame_words;
    assign frame_status   = r_frame_status;
    assign error_code     = r_error_code;
    assign busy           = r_busy;

endmodule : coax_rx_frame_ctrl
`default_nettype wire

// File: doc/coax_rx_frame_ctrl.md
# coax_rx_frame_ctrl

Frame-level controller that sits between `coax_buffered_rx` and the host register/DMA logic. It sequences reads from the receive FIFO and delivers words through a valid/ready stream. It detects frame boundaries, counts words, enforces a maximum frame length, and recovers the receiver after errors or host aborts by pulsing the receiver's reset and waiting for a quiet line.

## Interface
Parameters:
- `MAX_WORDS`, default 1024: words delivered per frame; further words are drained and discarded.
- `QUIET_CYCLES`, default 64: consecutive cycles of `rx_active` low required before re-arming after recovery.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  host arm; when low, IDLE does not start a new frame.
- `abort`  in  1  host abort, sampled in RECEIVE only.
- `rx_active`  in  1  from `coax_buffered_rx.active`.
- `rx_error`  in  1  from `coax_buffered_rx.error`.
- `rx_data`  in  10  from `coax_buffered_rx.data`; FIFO head when `!rx_empty`, error code when `rx_error`.
- `rx_empty`  in  1  FIFO empty.
- `rx_read_strobe`  out  1  pops the FIFO head.
- `rx_reset`  out  1  one-cycle pulse, ORed into the receiver's `reset` by the parent.
- `out_data`  out  10  stream word.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `frame_words`  out  11  words delivered in the last frame, saturating at `MAX_WORDS`; held until the next `frame_done`.
- `frame_status`  out  2  00 OK, 01 TRUNCATED, 10 ERROR, 11 ABORTED; held.
- `error_code`  out  10  `rx_data` captured on error; held.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RECEIVE, ERROR, RECOVER, QUIET.
- IDLE → RECEIVE when `enable && (rx_active || !rx_empty)`. On entry, clear the word counter and the truncated flag.
- RECEIVE, read rule: assert `rx_read_strobe = !rx_empty && !rx_error && (!out_valid || out_ready)`.
  - On a strobe, if count < `MAX_WORDS`: load `out_data` from `rx_data`, set `out_valid`, count++.
  - Otherwise the word is discarded, `out_valid` is not set, and the truncated flag is set.
- RECEIVE, end of frame: when `!rx_active && rx_empty && !out_valid && !rx_error`, pulse `frame_done` with status OK or TRUNCATED, then go to IDLE.
- RECEIVE → ERROR on `rx_error`. Error has priority over read, end-of-frame and abort in the same cycle.
- RECEIVE → RECOVER on `abort` (when no `rx_error`): clear `out_valid`, pulse `frame_done` with ABORTED.
- ERROR, one cycle:
  - capture `error_code`;
  - clear `out_valid`, dropping any pending word;
  - pulse `frame_done` with status ERROR and the current count;
  - go to RECOVER.
- `rx_error` in IDLE is also handled through ERROR, with count 0.
- RECOVER, one cycle: assert `rx_reset`, which flushes the FIFO and clears the overflow latch; go to QUIET.
- QUIET: count consecutive cycles with `rx_active` low, restarting at 0 whenever `rx_active` is high. After `QUIET_CYCLES` go to IDLE.
- `out_valid`, once set, deasserts only on a handshake (`out_valid && out_ready`) or on ERROR/abort flush.
- `out_data` is stable while `out_valid && !out_ready`.
- `enable` falling mid-frame has no effect until the frame ends.

## Timing
- All outputs are registered except `rx_read_strobe`, which is combinational from state and inputs.
- Reset values: state IDLE; every output 0; `frame_words`, `frame_status` and `error_code` all 0.
- Latency:
  - The strobe cycle loads the output register, so `out_valid` is high the next cycle.
  - With `out_ready` held high, throughput is 1 word per cycle.
- `frame_done` rises the cycle after the end condition or the ERROR/abort decision. `frame_words` and `frame_status` become valid in that same cycle.
- `rx_reset` is high exactly 1 cycle, 1 cycle after `frame_done` for an error or abort.
- Minimum re-arm time after an error: 1 (ERROR) + 1 (RECOVER) + `QUIET_CYCLES` cycles.
- The counter is 11 bits and saturates; it never wraps.
- Reset mid-frame: return to IDLE, drop `out_valid`, no `frame_done`. The parent resets the receiver from the same `reset`.

## Structure
- A shared `coax_pkg` holds:
  - the `frame_status` codes (OK, TRUNCATED, ERROR, ABORTED);
  - the state encoding;
  - the overflow error code 10'b0000001000, so benches can match `error_code`.
- No sub-module; the word counter and the quiet counter are inline.
- The parent wrapper `coax_rx_framed` instantiates `coax_buffered_rx` and this block, and ORs `rx_reset` with `reset`.

## Test plan
- 5-word frame, `out_ready` always 1 → words stream back-to-back, then `frame_done` with `frame_words`=5 and status 00.
- Same frame with `out_ready` toggling 1,0 → each word held stable while stalled, all 5 words delivered once, count 5.
- `MAX_WORDS`=4 with a 6-word frame → 4 words delivered, 2 strobed and discarded, `frame_words`=4, status 01.
- Overflow (`rx_error` with `rx_data`=10'h008) at word 3 → `out_valid` dropped, status 10, `error_code`=10'h008, `rx_reset` pulsed, IDLE only after 64 quiet cycles.
- `abort` mid-frame while `rx_active` stays high for 30 more cycles → status 11, `rx_reset` pulsed, and the QUIET count restarts until `rx_active` falls.
- `enable`=0 while data is in the FIFO → stays IDLE with no strobes. `enable` rising → frame received normally.
